// File: rtl/gcc_pkg.sv
// rtl/gcc_pkg.sv - shared types and constants for the gravity-centre calculator feeder
package gcc_pkg;

  localparam int GCC_WINDOW = 6;

  localparam int ERR_SHORT = 0;
  localparam int ERR_TRUNC = 1;
  localparam int ERR_PROTO = 2;

  localparam int PT_CW = 8;
  localparam int PT_WW = 4;

  typedef struct packed {
    logic [PT_CW-1:0] x;
    logic [PT_CW-1:0] y;
    logic [PT_WW-1:0] w;
  } point_t;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    DRAIN   = 3'd1,
    STREAM  = 3'd2,
    CAPTURE = 3'd3,
    RESULT  = 3'd4
  } state_e;

endpackage

// File: rtl/gcc_point_buf.sv
// rtl/gcc_point_buf.sv - frame point store with one write port and a registered read port
module gcc_point_buf #(
  parameter int DEPTH = 16,
  parameter int DW    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value when idle so the last streamed point stays on the bus.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gcc_feeder.sv
// rtl/gcc_feeder.sv - buffers one frame of weighted points, streams it gap-free into gcc
// and returns the captured centre over a valid/ready result handshake.
module gcc_feeder
  import gcc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 8,
  parameter int WW    = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CW-1:0]          in_x,
  input  logic [CW-1:0]          in_y,
  input  logic [WW-1:0]          in_w,
  input  logic                   in_last,
  output logic                   gcc_rst_n,
  output logic [CW-1:0]          gcc_x,
  output logic [CW-1:0]          gcc_y,
  output logic [WW-1:0]          gcc_w,
  input  logic                   gcc_ready_n,
  input  logic [CW-1:0]          gcc_xc,
  input  logic [CW-1:0]          gcc_yc,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CW-1:0]          res_x,
  output logic [CW-1:0]          res_y,
  output logic [$clog2(DEPTH):0] res_count,
  output logic [2:0]             res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int DW = 2 * CW + WW;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]   n_q, n_d;
  logic [NW-1:0]   idx_q, idx_d;
  logic            trunc_q, trunc_d;
  logic            in_ready_q, in_ready_d;
  logic            gcc_rst_n_q, gcc_rst_n_d;
  logic            res_valid_q, res_valid_d;
  logic [CW-1:0]   res_x_q, res_x_d;
  logic [CW-1:0]   res_y_q, res_y_d;
  logic [NW-1:0]   res_count_q, res_count_d;
  logic [2:0]      res_err_q, res_err_d;

  logic            accept;
  logic            wr_en;
  logic            rd_en;
  logic [DW-1:0]   rd_data;

  assign accept = in_valid & in_ready_q;

  gcc_point_buf #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_buf (
    .clk     (CLK),
    .rst     (RESET),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data ({in_x, in_y, in_w}),
    .rd_en   (rd_en),
    .rd_addr (idx_q[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    n_d         = n_q;
    idx_d       = idx_q;
    trunc_d     = trunc_q;
    gcc_rst_n_d = 1'b0;
    res_valid_d = res_valid_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_count_d = res_count_q;
    res_err_d   = res_err_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (in_last) begin
            n_d     = NW'(wr_ptr_q) + NW'(1);
            idx_d   = '0;
            state_d = STREAM;
          end else if (wr_ptr_q == AW'(DEPTH - 1)) begin
            n_d     = NW'(DEPTH);
            trunc_d = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // idx == n is the hold cycle: calculator samples the last point while reset is re-armed.
        if (idx_q < n_q) begin
          rd_en       = 1'b1;
          gcc_rst_n_d = 1'b1;
          idx_d       = idx_q + NW'(1);
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        res_x_d              = gcc_xc;
        res_y_d              = gcc_yc;
        res_count_d          = n_q;
        res_err_d            = '0;
        res_err_d[ERR_SHORT] = (n_q < NW'(GCC_WINDOW));
        res_err_d[ERR_TRUNC] = trunc_q;
        res_err_d[ERR_PROTO] = gcc_ready_n && (n_q >= NW'(GCC_WINDOW));
        res_valid_d          = 1'b1;
        state_d              = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          wr_ptr_d    = '0;
          trunc_d     = 1'b0;
          state_d     = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    in_ready_d = (state_d == LOAD) || (state_d == DRAIN);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      trunc_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      gcc_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_count_q <= '0;
      res_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      trunc_q     <= trunc_d;
      in_ready_q  <= in_ready_d;
      gcc_rst_n_q <= gcc_rst_n_d;
      res_valid_q <= res_valid_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_count_q <= res_count_d;
      res_err_q   <= res_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign gcc_rst_n = gcc_rst_n_q;
  assign gcc_x     = rd_data[DW-1 -: CW];
  assign gcc_y     = rd_data[WW +: CW];
  assign gcc_w     = rd_data[WW-1:0];
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_count = res_count_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_gcc_feeder.sv
// tb/tb_gcc_feeder.sv - directed frames against a frame-level model, with a behavioural gcc stub
module tb_gcc_feeder;
  import gcc_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int WW    = 4;

  logic          CLK;
  logic          RESET;
  logic          in_valid, in_ready, in_last;
  logic [CW-1:0] in_x, in_y;
  logic [WW-1:0] in_w;
  logic          gcc_rst_n, gcc_ready_n;
  logic [CW-1:0] gcc_x, gcc_y, gcc_xc, gcc_yc;
  logic [WW-1:0] gcc_w;
  logic          res_valid, res_ready;
  logic [CW-1:0] res_x, res_y;
  logic [4:0]    res_count;
  logic [2:0]    res_err;

  gcc_feeder #(.DEPTH(DEPTH), .CW(CW), .WW(WW)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_w(in_w), .in_last(in_last),
    .gcc_rst_n(gcc_rst_n), .gcc_x(gcc_x), .gcc_y(gcc_y), .gcc_w(gcc_w),
    .gcc_ready_n(gcc_ready_n), .gcc_xc(gcc_xc), .gcc_yc(gcc_yc),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_count(res_count), .res_err(res_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // gcc stub: samples a point on every edge out of reset, centre of the last six samples, rounded.
  logic [CW-1:0] hx [6];
  logic [CW-1:0] hy [6];
  logic [WW-1:0] hw [6];
  int            hcnt;
  int            sw, sx, sy;

  always @(posedge CLK) begin
    if (!gcc_rst_n) begin
      for (int i = 0; i < 6; i++) begin
        hx[i] <= '0; hy[i] <= '0; hw[i] <= '0;
      end
      hcnt <= 0;
    end else begin
      hx[0] <= gcc_x; hy[0] <= gcc_y; hw[0] <= gcc_w;
      for (int i = 1; i < 6; i++) begin
        hx[i] <= hx[i-1]; hy[i] <= hy[i-1]; hw[i] <= hw[i-1];
      end
      if (hcnt < 6) hcnt <= hcnt + 1;
    end
  end

  always_comb begin
    sw = 0; sx = 0; sy = 0;
    for (int i = 0; i < 6; i++) begin
      sw = sw + int'(hw[i]);
      sx = sx + int'(hw[i]) * int'(hx[i]);
      sy = sy + int'(hw[i]) * int'(hy[i]);
    end
    gcc_xc      = (sw == 0) ? 8'd0 : 8'((sx + sw / 2) / sw);
    gcc_yc      = (sw == 0) ? 8'd0 : 8'((sy + sw / 2) / sw);
    gcc_ready_n = (hcnt < 6);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model state
  point_t exp_pt [DEPTH];
  int     n_acc = 0, exp_n = 0, sk = 0, ri = 0, wait_cyc = 0;
  bit     pending = 0, exp_trunc = 0, rst_pend = 0, done = 0, done_seen = 0;

  int lit_x [6] = '{10, 5, -1, 13, 10, 7};
  int lit_y [6] = '{20, 5, -1, 25, 97, 9};
  int lit_n [6] = '{6, 6, 3, 16, 6, 6};
  int lit_e [6] = '{0, 0, 1, 2, 0, 0};

  function automatic int centre(input bit use_y);
    int s = 0;
    int w = 0;
    for (int i = exp_n - GCC_WINDOW; i < exp_n; i++) begin
      w += int'(exp_pt[i].w);
      s += int'(exp_pt[i].w) * (use_y ? int'(exp_pt[i].y) : int'(exp_pt[i].x));
    end
    return (w == 0) ? 0 : (s + w / 2) / w;
  endfunction

  always @(negedge CLK) begin
    if (RESET) begin
      pending = 0; n_acc = 0; sk = 0; exp_n = 0; wait_cyc = 0; rst_pend = 1;
    end else begin
      if (rst_pend) begin
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_gcc_rst_n", int'(gcc_rst_n), 0);
        chk("rst_gcc_x", int'(gcc_x), 0);
        chk("rst_gcc_y", int'(gcc_y), 0);
        chk("rst_gcc_w", int'(gcc_w), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_x", int'(res_x), 0);
        chk("rst_res_y", int'(res_y), 0);
        chk("rst_res_count", int'(res_count), 0);
        chk("rst_res_err", int'(res_err), 0);
        rst_pend = 0;
      end else begin
        if (pending) chk("no_overlap_in_ready", int'(in_ready), 0);
        if (gcc_rst_n) begin
          if (pending && sk < exp_n) begin
            chk("stream_x", int'(gcc_x), int'(exp_pt[sk].x));
            chk("stream_y", int'(gcc_y), int'(exp_pt[sk].y));
            chk("stream_w", int'(gcc_w), int'(exp_pt[sk].w));
          end else begin
            chk("stream_unexpected", int'(gcc_rst_n), 0);
          end
          sk++;
        end
        if (res_valid) begin
          if (!pending) begin
            chk("res_unexpected", int'(res_valid), 0);
          end else begin
            chk("res_count", int'(res_count), exp_n);
            chk("res_err", int'(res_err), (exp_trunc ? 2 : 0) + (exp_n < GCC_WINDOW ? 1 : 0));
            chk("stream_len", sk, exp_n);
            chk("res_gcc_rst_n", int'(gcc_rst_n), 0);
            if (exp_n >= GCC_WINDOW) begin
              chk("res_x", int'(res_x), centre(1'b0));
              chk("res_y", int'(res_y), centre(1'b1));
            end
            if (res_ready) begin
              if (ri < 6) begin
                if (lit_x[ri] >= 0) begin
                  chk("lit_res_x", int'(res_x), lit_x[ri]);
                  chk("lit_res_y", int'(res_y), lit_y[ri]);
                end
                chk("lit_res_count", int'(res_count), lit_n[ri]);
                chk("lit_res_err", int'(res_err), lit_e[ri]);
              end else begin
                chk("extra_result", ri, 5);
              end
              ri++; pending = 0; sk = 0; wait_cyc = 0;
            end
          end
        end
        if (pending) begin
          wait_cyc++;
          if (wait_cyc == 400) chk("result_timeout", wait_cyc, 0);
        end
        if (in_valid && in_ready) begin
          if (n_acc < DEPTH) exp_pt[n_acc] = {in_x, in_y, in_w};
          n_acc++;
          if (in_last) begin
            exp_n     = (n_acc > DEPTH) ? DEPTH : n_acc;
            exp_trunc = (n_acc > DEPTH);
            pending   = 1; n_acc = 0; sk = 0; wait_cyc = 0;
          end
        end
        if (done && !done_seen) begin
          chk("result_total", ri, 6);
          done_seen = 1;
        end
      end
    end
  end

  int fx [32];
  int fy [32];
  int fw [32];

  task automatic send_frame(input int n);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 2000) begin
      in_valid = 1'b1;
      in_x     = 8'(fx[i]);
      in_y     = 8'(fy[i]);
      in_w     = 4'(fw[i]);
      in_last  = (i == n - 1);
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK); #1;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input int hold);
    int g = 0;
    while (!res_valid && g < 300) begin
      @(posedge CLK); #1;
      g++;
    end
    repeat (hold) begin
      @(posedge CLK); #1;
    end
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    int k, g;
    RESET = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_x = '0; in_y = '0; in_w = '0; res_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    for (int i = 0; i < 6; i++) begin fx[i] = 10; fy[i] = 20; fw[i] = 1; end
    send_frame(6);
    get_result(0);

    fx[0] = 0;  fy[0] = 0;  fw[0] = 1;
    fx[1] = 10; fy[1] = 0;  fw[1] = 1;
    fx[2] = 0;  fy[2] = 10; fw[2] = 1;
    fx[3] = 10; fy[3] = 10; fw[3] = 1;
    fx[4] = 5;  fy[4] = 5;  fw[4] = 2;
    fx[5] = 5;  fy[5] = 5;  fw[5] = 2;
    send_frame(6);
    get_result(0);

    for (int i = 0; i < 3; i++) begin fx[i] = 3 * i + 1; fy[i] = 3 * i + 2; fw[i] = 3 * i + 3; end
    send_frame(3);
    get_result(0);

    for (int i = 0; i < 20; i++) begin fx[i] = i; fy[i] = 2 * i; fw[i] = 1; end
    send_frame(20);
    get_result(0);

    for (int i = 0; i < 6; i++) begin fx[i] = 3 * i; fy[i] = 100 - i; fw[i] = i + 1; end
    send_frame(6);
    get_result(10);

    for (int i = 0; i < 6; i++) begin fx[i] = 20 + i; fy[i] = 30 + i; fw[i] = 3; end
    send_frame(6);
    k = 0; g = 0;
    while (k < 4 && g < 60) begin
      @(posedge CLK); #1;
      if (gcc_rst_n) k++;
      g++;
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end

    for (int i = 0; i < 6; i++) begin fx[i] = 7; fy[i] = 9; fw[i] = 2; end
    send_frame(6);
    get_result(0);

    repeat (3) begin @(posedge CLK); #1; end
    done = 1'b1;
    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
